// File: rtl/frame_receiver.sv
// frame_receiver
//   Receive-side framer. Hunts the byte stream for the 48-bit MAGIC word,
//   captures the following frame_length 16-bit payload words into a word
//   buffer and holds them until the consumer releases them with frame_ack.
//   A frame that arrives while the buffer is still held is consumed and
//   dropped.
//
//   Optional build macro FRAME_RECEIVER_CHECKSUM_EN: each frame carries a
//   trailer word equal to the mod-2^16 sum of its payload words. A captured
//   frame with a bad trailer pulses checksum_err and is not flagged ready.
//   Without the macro no trailer is expected and checksum_err is tied low.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   rxd, rxd_valid  received byte and its qualifier
//   read_addr       buffer word address (>= frame_length reads as 0)
//   read_data       buffer word, registered, one cycle after read_addr
//   frame_ready     a complete frame is held in the buffer
//   frame_ack       consumer release pulse
//   busy            payload capture in progress
//   frame_complete  pulse when a frame becomes ready
//   frame_drop      pulse when a frame is discarded
//   frame_count     accepted frames, wrapping
//   checksum_err    pulse on trailer mismatch
//
// state   | meaning
// HUNT    | shifting valid bytes through the magic window
// CAPTURE | storing payload (and trailer) bytes into the buffer
// DISCARD | buffer held by consumer, skipping the whole frame
module frame_receiver #(
  parameter int          frame_length = 4,
  parameter logic [47:0] MAGIC        = 48'hF6F6F6282828
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rxd_valid,
  input  logic [7:0]  read_addr,
  output logic [15:0] read_data,
  output logic        frame_ready,
  input  logic        frame_ack,
  output logic        busy,
  output logic        frame_complete,
  output logic        frame_drop,
  output logic [15:0] frame_count,
  output logic        checksum_err
);

  localparam int         AW        = (frame_length > 1) ? $clog2(frame_length) : 1;
  localparam logic [8:0] LAST_BYTE = 9'(2 * frame_length - 1);

  typedef enum logic [1:0] {HUNT, CAPTURE, DISCARD} state_t;

  state_t        state;
  // Only the five previous bytes are stored; the incoming byte completes
  // the 48-bit window, so the match is on the value after the shift.
  logic [39:0]   shift_reg;
  logic [47:0]   window;
  logic [8:0]    byte_cnt;
  logic [7:0]    hi_byte;
  logic          trailer;
  logic          phase_last;
  logic [15:0]   rx_word;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          done_pend;
  logic [15:0]   buf_mem [frame_length];
`ifdef FRAME_RECEIVER_CHECKSUM_EN
  logic [15:0]   sum;
`endif

  assign window     = {shift_reg, rxd};
  assign rx_word    = {hi_byte, rxd};
  // byte_cnt restarts at 0 for the two trailer bytes
  assign phase_last = trailer ? (byte_cnt == 9'd1) : (byte_cnt == LAST_BYTE);

`ifndef FRAME_RECEIVER_CHECKSUM_EN
  assign checksum_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      shift_reg      <= '0;
      byte_cnt       <= '0;
      hi_byte        <= '0;
      trailer        <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      done_pend      <= 1'b0;
      frame_ready    <= 1'b0;
      busy           <= 1'b0;
      frame_complete <= 1'b0;
      frame_drop     <= 1'b0;
      frame_count    <= '0;
`ifdef FRAME_RECEIVER_CHECKSUM_EN
      sum            <= '0;
      checksum_err   <= 1'b0;
`endif
    end else begin
      frame_complete <= 1'b0;
      frame_drop     <= 1'b0;
      wr_en          <= 1'b0;
      done_pend      <= 1'b0;
`ifdef FRAME_RECEIVER_CHECKSUM_EN
      checksum_err   <= 1'b0;
`endif
      // Completion lands together with the last buffer write, and a new
      // frame wins over a release sampled on the same edge.
      if (done_pend) begin
        frame_ready    <= 1'b1;
        frame_complete <= 1'b1;
        frame_count    <= frame_count + 16'd1;
        busy           <= 1'b0;
      end else if (frame_ack) begin
        frame_ready <= 1'b0;
      end

      if (rxd_valid) begin
        case (state)
          HUNT: begin
            shift_reg <= window[39:0];
            if (window == MAGIC) begin
              byte_cnt <= '0;
              trailer  <= 1'b0;
`ifdef FRAME_RECEIVER_CHECKSUM_EN
              sum      <= '0;
`endif
              if (frame_ready) begin
                state <= DISCARD;
              end else begin
                state <= CAPTURE;
                busy  <= 1'b1;
              end
            end
          end
          CAPTURE: begin
            byte_cnt <= byte_cnt + 9'd1;
            if (!byte_cnt[0]) begin
              hi_byte <= rxd;
            end else if (!trailer) begin
              wr_en   <= 1'b1;
              wr_addr <= byte_cnt[AW:1];
              wr_data <= rx_word;
`ifdef FRAME_RECEIVER_CHECKSUM_EN
              sum     <= sum + rx_word;
`endif
            end
            if (phase_last) begin
`ifdef FRAME_RECEIVER_CHECKSUM_EN
              if (!trailer) begin
                trailer  <= 1'b1;
                byte_cnt <= '0;
              end else begin
                shift_reg <= '0;
                state     <= HUNT;
                if (rx_word == sum) begin
                  done_pend <= 1'b1;
                end else begin
                  checksum_err <= 1'b1;
                  busy         <= 1'b0;
                end
              end
`else
              shift_reg <= '0;
              state     <= HUNT;
              done_pend <= 1'b1;
`endif
            end
          end
          DISCARD: begin
            byte_cnt <= byte_cnt + 9'd1;
            if (phase_last) begin
`ifdef FRAME_RECEIVER_CHECKSUM_EN
              if (!trailer) begin
                trailer  <= 1'b1;
                byte_cnt <= '0;
              end else begin
                frame_drop <= 1'b1;
                shift_reg  <= '0;
                state      <= HUNT;
              end
`else
              frame_drop <= 1'b1;
              shift_reg  <= '0;
              state      <= HUNT;
`endif
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (int'(read_addr) < frame_length) begin
      read_data <= buf_mem[read_addr[AW-1:0]];
    end else begin
      read_data <= '0;
    end
  end

endmodule
